// File: rtl/fm_uart_pkg.sv
// fm_uart_pkg: shared types and helpers for the word-to-byte serializer
// Contents:
//   state_e    serializer FSM encoding (IDLE, SYNC, SEND)
//   SYNC_BYTE  header byte sent ahead of each word when SPLIT_SYNC_EN is defined
//   clog2      ceiling log2 usable in parameter and port-width expressions
package fm_uart_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, SEND = 2'd2} state_e;
   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: DEPTH x W word FIFO with fill level; writes while full are dropped
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_i         write request (ignored when full unless a pop happens in the same cycle)
//   rd_i         pop request (ignored when empty)
//   data_i       write data
//   data_o       head word (valid whenever level_o != 0)
//   level_o      current fill level, 0..DEPTH
module sync_fifo
   import fm_uart_pkg::*;
#(
   parameter int W     = 32,
   parameter int DEPTH = 4
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_i,
   input  logic                  rd_i,
   input  logic [W-1:0]          data_i,
   output logic [W-1:0]          data_o,
   output logic [clog2(DEPTH):0] level_o
);
   localparam int AW = clog2(DEPTH);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   level_q;
   logic          wr_en, rd_en;
   assign rd_en = rd_i && (level_q != '0);
   // a pop in the same cycle frees the slot, so a write at full is still taken
   assign wr_en = wr_i && ((level_q != (AW+1)'(DEPTH)) || rd_en);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_q + AW'(wr_en);
         rptr_q  <= rptr_q + AW'(rd_en);
         level_q <= level_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      end
   end
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q] <= data_i;
   end
   assign data_o  = mem_q[rptr_q];
   assign level_o = level_q;
endmodule

// File: rtl/word_serializer.sv
// word_serializer: buffers 2*WIDTH-bit sample words and streams them byte-wise over valid/ready
// Build option: define SPLIT_SYNC_EN to precede every word with the header byte SYNC_BYTE.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   word_stb_i      one-cycle strobe capturing data_i (no backpressure; dropped when FIFO full)
//   data_i          merged sample word
//   clr_ovf_i       clears overflow_o (a simultaneous overflow wins)
//   byte_o          registered output byte, held while byte_valid_o && !byte_ready_i
//   byte_valid_o    byte_o valid
//   byte_ready_i    consumer accepts byte_o
//   busy_o          FIFO non-empty or a word in flight
//   level_o         FIFO fill level
//   overflow_o      sticky: a word was dropped because the FIFO was full
module word_serializer
   import fm_uart_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 4,
   parameter int LSB_FIRST = 0
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  word_stb_i,
   input  logic [2*WIDTH-1:0]    data_i,
   input  logic                  clr_ovf_i,
   output logic [7:0]            byte_o,
   output logic                  byte_valid_o,
   input  logic                  byte_ready_i,
   output logic                  busy_o,
   output logic [clog2(DEPTH):0] level_o,
   output logic                  overflow_o
);
   localparam int NB = 2*WIDTH/8;
   localparam int CW = clog2(NB+1);
   localparam int LW = clog2(DEPTH)+1;
   localparam logic [CW-1:0] LAST = CW'(NB-1);
   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] shift_q, shift_d, head;
   logic [7:0]         byte_q, byte_d, first_byte;
   logic               valid_q, valid_d, ovf_q, ovf_d, pop, full, empty;
   function automatic logic [7:0] pick(input logic [2*WIDTH-1:0] w, input logic [CW-1:0] k);
      int idx;
      idx = (LSB_FIRST != 0) ? int'(k) : NB - 1 - int'(k);
      return w[8*idx +: 8];
   endfunction
`ifdef SPLIT_SYNC_EN
   localparam state_e FIRST = SYNC;
   assign first_byte = SYNC_BYTE;
`else
   localparam state_e FIRST = SEND;
   assign first_byte = pick(head, '0);
`endif
   sync_fifo #(.W(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_i    (word_stb_i),
      .rd_i    (pop),
      .data_i  (data_i),
      .data_o  (head),
      .level_o (level_o)
   );
   assign empty = level_o == '0;
   assign full  = level_o == LW'(DEPTH);
   assign ovf_d = (word_stb_i && full && !pop) || (ovf_q && !clr_ovf_i);
   // The first byte of a word from IDLE is presented one cycle after the pop
   // (valid_q low in SYNC/SEND); follow-on words load their first byte directly
   // on the final handshake so there is no bubble between words.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      valid_d = valid_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            cnt_d   = '0;
            state_d = FIRST;
         end
`ifdef SPLIT_SYNC_EN
         SYNC: if (!valid_q) begin
            byte_d  = SYNC_BYTE;
            valid_d = 1'b1;
         end else if (byte_ready_i) begin
            byte_d  = pick(shift_q, '0);
            state_d = SEND;
         end
`endif
         SEND: if (!valid_q) begin
            byte_d  = pick(shift_q, cnt_q);
            valid_d = 1'b1;
         end else if (byte_ready_i) begin
            if (cnt_q != LAST) begin
               cnt_d  = cnt_q + 1'b1;
               byte_d = pick(shift_q, cnt_q + 1'b1);
            end else if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               cnt_d   = '0;
               byte_d  = first_byte;
               state_d = FIRST;
            end else begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         byte_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end
   assign byte_o       = byte_q;
   assign byte_valid_o = valid_q;
   assign overflow_o   = ovf_q;
   assign busy_o       = !empty || (state_q != IDLE);
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: scoreboard bench for word_serializer, MSB-first and LSB-first instances side by side
module tb_word_serializer;
   localparam int NB = 4;
   localparam int DEPTH = 4;
`ifdef SPLIT_SYNC_EN
   localparam int NBW = NB + 1;
   localparam logic [7:0] F0 = 8'hA5, F1 = 8'hA5;
`else
   localparam int NBW = NB;
   localparam logic [7:0] F0 = 8'h12, F1 = 8'h78;
`endif
   logic        clk = 1'b0, rst_n = 1'b0, stb = 1'b0, clr = 1'b0, rdy = 1'b0;
   logic [31:0] data = '0;
   logic [7:0]  byte0, byte1;
   logic        valid0, valid1, busy0, busy1, ovf0, ovf1;
   logic [2:0]  level0, level1;
   logic [7:0]  q0[$], q1[$];
   int          n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   word_serializer #(.WIDTH(16), .DEPTH(DEPTH), .LSB_FIRST(0)) d0 (
      .clk(clk), .rst_n(rst_n), .word_stb_i(stb), .data_i(data), .clr_ovf_i(clr),
      .byte_o(byte0), .byte_valid_o(valid0), .byte_ready_i(rdy),
      .busy_o(busy0), .level_o(level0), .overflow_o(ovf0));
   word_serializer #(.WIDTH(16), .DEPTH(DEPTH), .LSB_FIRST(1)) d1 (
      .clk(clk), .rst_n(rst_n), .word_stb_i(stb), .data_i(data), .clr_ovf_i(clr),
      .byte_o(byte1), .byte_valid_o(valid1), .byte_ready_i(rdy),
      .busy_o(busy1), .level_o(level1), .overflow_o(ovf1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // expected byte order of one word for each instance
   task automatic push_word(input logic [31:0] d);
`ifdef SPLIT_SYNC_EN
      q0.push_back(8'hA5);
      q1.push_back(8'hA5);
`endif
      for (int k = 0; k < NB; k++) begin
         q0.push_back(d[8*(NB-1-k) +: 8]);
         q1.push_back(d[8*k +: 8]);
      end
   endtask

   // one clock cycle, entered and left at a falling edge
   task automatic cyc(input bit s, input logic [31:0] d, input bit r, input bit c, input bit acc);
      chk("busy0", busy0, q0.size() != 0);
      chk("busy1", busy1, q1.size() != 0);
      if (valid0) begin
         if (q0.size() != 0) chk("byte0", byte0, q0[0]);
         else chk("spur0", valid0, 0);
      end
      if (valid1) begin
         if (q1.size() != 0) chk("byte1", byte1, q1[0]);
         else chk("spur1", valid1, 0);
      end
      stb = s; data = d; rdy = r; clr = c;
      if (valid0 && r && q0.size() != 0) void'(q0.pop_front());
      if (valid1 && r && q1.size() != 0) void'(q1.pop_front());
      if (s && acc) push_word(d);
      @(negedge clk);
      stb = 1'b0; clr = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && q0.size() != 0; i++) cyc(0, '0, 1, 0, 0);
      chk("drained0", q0.size(), 0);
      chk("drained1", q1.size(), 0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_byte0"}, byte0, 0);
      chk({tag, "_valid0"}, valid0, 0);
      chk({tag, "_busy0"}, busy0, 0);
      chk({tag, "_level0"}, level0, 0);
      chk({tag, "_ovf0"}, ovf0, 0);
      chk({tag, "_valid1"}, valid1, 0);
      chk({tag, "_level1"}, level1, 0);
      chk({tag, "_ovf1"}, ovf1, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_reset("rst");
      rst_n = 1'b1;
      @(negedge clk);
      // latency and byte order
      cyc(1, 32'h1234_5678, 1, 0, 1);
      chk("lat_t0", valid0, 0);
      cyc(0, '0, 1, 0, 0);
      chk("lat_t1", valid0, 0);
      cyc(0, '0, 1, 0, 0);
      chk("lat_t2", valid0, 1);
      chk("first0", byte0, F0);
      chk("first1", byte1, F1);
      for (int i = 0; i < NBW; i++) cyc(0, '0, 1, 0, 0);
      chk("tput_left", q0.size(), 0);
      chk("tput_end", valid0, 0);
      // back-to-back words with ready high: no gap between words
      cyc(1, 32'hDEAD_BEEF, 1, 0, 1);
      cyc(1, 32'h0102_0304, 1, 0, 1);
      cyc(0, '0, 1, 0, 0);
      for (int i = 0; i < 2*NBW; i++) cyc(0, '0, 1, 0, 0);
      chk("b2b_left", q0.size(), 0);
      // stall mid-word
      cyc(1, 32'hCAFE_F00D, 1, 0, 1);
      for (int i = 0; i < 12; i++) cyc(0, '0, !(i >= 3 && i < 8), 0, 0);
      drain();
      // fill to overflow with ready low
      for (int k = 0; k < 6; k++) cyc(1, 32'hA0B0_C000 + k, 0, 0, k < 5);
      chk("full_level", level0, 4);
      chk("ovf_set", ovf0, 1);
      cyc(1, 32'hDEAD_DEAD, 0, 1, 0);
      chk("ovf_set_wins", ovf0, 1);
      cyc(0, '0, 0, 1, 0);
      chk("ovf_clr", ovf0, 0);
      // strobe on the final handshake of the in-flight word while full
      for (int k = 0; k < NBW; k++) cyc(k == NBW-1, 32'h600D_F00D, 1, 0, 1);
      chk("wr_pop_level", level0, 4);
      chk("wr_pop_ovf", ovf0, 0);
      drain();
      for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0, 0);
      // reset in the middle of a word
      cyc(1, 32'h55AA_33CC, 1, 0, 1);
      for (int i = 0; i < 20 && q0.size() > NBW-2; i++) cyc(0, '0, 1, 0, 0);
      rst_n = 1'b0;
      #1;
      chk_reset("midrst");
      q0.delete();
      q1.delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0, 0);
      cyc(1, 32'h0BAD_CAFE, 1, 0, 1);
      drain();
      // random traffic, strobes only while the FIFO cannot overflow
      for (int i = 0; i < 400; i++) begin
         int words;
         bit s;
         words = (q0.size() + NBW - 1) / NBW;
         chk("lvl_bound", level0 <= 3'(words), 1);
         chk("ovf_rand", ovf0, 0);
         s = ($urandom_range(0, 2) == 0) && (words < DEPTH);
         cyc(s, $urandom, $urandom_range(0, 3) != 0, 0, 1);
      end
      drain();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
